// File: rtl/stfft_pkg.sv
// rtl/stfft_pkg.sv - shared FSM state type and width helpers for the STFFT frame buffer
package stfft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Address width of the sample store, which holds two frames' worth of samples.
  function automatic int addr_w(input int fft_size);
    return $clog2(2 * fft_size);
  endfunction

  // Width of the position-within-frame index.
  function automatic int idx_w(input int fft_size);
    return $clog2(fft_size);
  endfunction

endpackage

// File: rtl/stfft_sample_ram.sv
// rtl/stfft_sample_ram.sv - simple dual-port sample store, one write port and one synchronous read port
module stfft_sample_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Sample array write; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its word when re is low so a stalled beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stfft_frame_buffer.sv
// rtl/stfft_frame_buffer.sv - circular sample buffer replaying overlapping STFFT frames over a valid/ready stream
module stfft_frame_buffer
  import stfft_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FFT_SIZE = 256,
  parameter int HOP_SIZE = 128,
  parameter int FNUM_W   = 16,
  localparam int IDX_W   = idx_w(FFT_SIZE)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic [DATA_W-1:0] frame_data_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic [IDX_W-1:0]  frame_idx_o,
  output logic              frame_start_o,
  output logic              frame_last_o,
  output logic [FNUM_W-1:0] frame_num_o,
  output logic              primed_o,
  output logic              overrun_o
);

  localparam int ADDR_W = addr_w(FFT_SIZE);
  localparam int DEPTH  = 2 * FFT_SIZE;

  localparam logic [IDX_W:0]    FILL_FULL  = (IDX_W+1)'(FFT_SIZE);
  localparam logic [IDX_W:0]    FILL_LAST  = (IDX_W+1)'(FFT_SIZE - 1);
  localparam logic [IDX_W-1:0]  HOP_LAST   = IDX_W'(HOP_SIZE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(FFT_SIZE - 1);
  localparam logic [ADDR_W-1:0] FRAME_SPAN = ADDR_W'(FFT_SIZE);

  state_t            state;
  state_t            state_n;

  logic [ADDR_W-1:0] wr_ptr;
  logic [IDX_W:0]    fill_cnt;
  logic [IDX_W-1:0]  hop_cnt;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [FNUM_W-1:0] frame_num;

  logic              wr_en;
  logic              first_trig;
  logic              hop_trig;
  logic              trig;
  logic [ADDR_W-1:0] trig_base;
  logic              rd_en;
  logic              load;
  logic              advance;
  logic              finish;

  // Write qualification and frame trigger detection; a flushed sample is never written.
  always_comb begin
    wr_en      = sample_valid_i && !flush_i;
    first_trig = wr_en && (fill_cnt == FILL_LAST);
    hop_trig   = wr_en && (fill_cnt == FILL_FULL) && (hop_cnt == HOP_LAST);
    trig       = first_trig || hop_trig;
    // Oldest sample of the frame: write pointer after this write, minus one frame.
    trig_base  = wr_ptr + ADDR_W'(1) - FRAME_SPAN;
  end

  // Write pointer, saturating fill count and hop count.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fill_cnt != FILL_FULL) begin
        fill_cnt <= fill_cnt + (IDX_W+1)'(1);
      end
      // Hop counting starts at the first trigger and keeps running through dropped frames.
      if (trig) begin
        hop_cnt <= '0;
      end else if (fill_cnt == FILL_FULL) begin
        hop_cnt <= hop_cnt + IDX_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          load    = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_n = ST_STREAM;
      end
      ST_STREAM: begin
        // Each accepted beat prefetches the next word so back-to-back beats need no bubble.
        if (frame_ready_i) begin
          rd_en   = 1'b1;
          advance = 1'b1;
          if (idx == IDX_LAST) begin
            finish  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush_i) begin
      state_n = ST_IDLE;
      rd_en   = 1'b0;
      load    = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
    end
  end

  // Read address, frame position and frame sequence number.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_addr   <= '0;
      idx       <= '0;
      frame_num <= '0;
    end else if (flush_i) begin
      rd_addr   <= '0;
      idx       <= '0;
      frame_num <= '0;
    end else begin
      if (load) begin
        rd_addr <= trig_base;
        idx     <= '0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      if (advance) begin
        idx <= idx + IDX_W'(1);
      end
      if (finish) begin
        frame_num <= frame_num + FNUM_W'(1);
      end
    end
  end

  stfft_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .rst_n (reset_ni),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (sample_i),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (frame_data_o)
  );

  // Stream outputs and status flags; a trigger while busy is dropped and reported.
  always_comb begin
    frame_valid_o = (state == ST_STREAM);
    frame_idx_o   = idx;
    frame_start_o = frame_valid_o && (idx == '0);
    frame_last_o  = frame_valid_o && (idx == IDX_LAST);
    frame_num_o   = frame_num;
    primed_o      = (fill_cnt == FILL_FULL);
    overrun_o     = trig && (state != ST_IDLE);
  end

endmodule

// File: tb/tb_stfft_frame_buffer.sv
// tb/tb_stfft_frame_buffer.sv - directed self-checking bench for stfft_frame_buffer
module tb_stfft_frame_buffer;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        flush_i;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic [15:0] frame_data_o;
  logic        frame_valid_o;
  logic        frame_ready_i;
  logic [2:0]  frame_idx_o;
  logic        frame_start_o;
  logic        frame_last_o;
  logic [15:0] frame_num_o;
  logic        primed_o;
  logic        overrun_o;

  stfft_frame_buffer #(
    .DATA_W   (16),
    .FFT_SIZE (8),
    .HOP_SIZE (4),
    .FNUM_W   (16)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .flush_i        (flush_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .frame_data_o   (frame_data_o),
    .frame_valid_o  (frame_valid_o),
    .frame_ready_i  (frame_ready_i),
    .frame_idx_o    (frame_idx_o),
    .frame_start_o  (frame_start_o),
    .frame_last_o   (frame_last_o),
    .frame_num_o    (frame_num_o),
    .primed_o       (primed_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int beat = 0;
  int exp_first = 1;
  int exp_fnum = 0;
  int frames_done = 0;
  int ovr_cnt = 0;
  int ovr_at [4];
  int valid_cycles = 0;
  bit held = 1'b0;
  logic [15:0] held_data;
  logic [2:0]  held_idx;
  logic [15:0] rpat;
  logic [3:0]  rk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, observe the cycle, then advance to just after the edge.
  task automatic step(input logic sv, input logic [15:0] s, input logic rdy, input logic fl);
    sample_valid_i = sv;
    sample_i       = s;
    frame_ready_i  = rdy;
    flush_i        = fl;
    #1;
    if (held) begin
      chk("stall_valid", 32'(frame_valid_o), 1);
      chk("stall_data", 32'(frame_data_o), 32'(held_data));
      chk("stall_idx", 32'(frame_idx_o), 32'(held_idx));
    end
    held = 1'b0;
    if (frame_valid_o) valid_cycles++;
    if (!fl && frame_valid_o) begin
      if (rdy) begin
        chk("beat_data", 32'(frame_data_o), 32'(exp_first + beat));
        chk("beat_idx", 32'(frame_idx_o), 32'(beat));
        chk("beat_start", 32'(frame_start_o), 32'(beat == 0));
        chk("beat_last", 32'(frame_last_o), 32'(beat == 7));
        chk("beat_fnum", 32'(frame_num_o), 32'(exp_fnum));
        beat++;
        if (beat == 8) begin
          beat = 0;
          exp_first += 4;
          exp_fnum++;
          frames_done++;
        end
      end else begin
        held      = 1'b1;
        held_data = frame_data_o;
        held_idx  = frame_idx_o;
      end
    end
    if (overrun_o) begin
      if (ovr_cnt < 4) ovr_at[ovr_cnt] = int'(s);
      ovr_cnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_until_frames(input int target, input int budget);
    for (int i = 0; i < budget && frames_done < target; i++) step(1'b0, 16'd0, 1'b1, 1'b0);
  endtask

  // Feed samples 1..8 from an empty buffer and check trigger latency and the frame.
  task automatic prime_run(input string tag);
    for (int v = 1; v <= 7; v++) step(1'b1, 16'(v), 1'b1, 1'b0);
    chk({tag, "_primed_before"}, 32'(primed_o), 0);
    step(1'b1, 16'd8, 1'b1, 1'b0);
    chk({tag, "_primed_after"}, 32'(primed_o), 1);
    chk({tag, "_valid_lat1"}, 32'(frame_valid_o), 0);
    step(1'b0, 16'd0, 1'b1, 1'b0);
    chk({tag, "_valid_lat2"}, 32'(frame_valid_o), 1);
    idle_until_frames(frames_done + 1, 20);
  endtask

  initial begin
    reset_ni       = 1'b0;
    flush_i        = 1'b0;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    frame_ready_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(frame_valid_o), 0);
    chk("rst_data", 32'(frame_data_o), 0);
    chk("rst_idx", 32'(frame_idx_o), 0);
    chk("rst_start", 32'(frame_start_o), 0);
    chk("rst_last", 32'(frame_last_o), 0);
    chk("rst_fnum", 32'(frame_num_o), 0);
    chk("rst_primed", 32'(primed_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    reset_ni = 1'b1;

    // Prime: frame 0 = 1..8
    prime_run("prime");
    chk("prime_frames", 32'(frames_done), 1);

    // Overlap: frames 5..12 and 9..16 with sparse samples
    for (int v = 9; v <= 16; v++) begin
      step(1'b1, 16'(v), 1'b1, 1'b0);
      repeat (3) step(1'b0, 16'd0, 1'b1, 1'b0);
    end
    idle_until_frames(3, 20);
    chk("overlap_frames", 32'(frames_done), 3);
    chk("overlap_ovr", 32'(ovr_cnt), 0);

    // Back-pressure: fixed half-density ready pattern
    rpat = 16'hA5C3;
    rk   = '0;
    for (int v = 17; v <= 28; v++) begin
      step(1'b1, 16'(v), rpat[rk], 1'b0);
      rk++;
      repeat (4) begin
        step(1'b0, 16'd0, rpat[rk], 1'b0);
        rk++;
      end
    end
    for (int i = 0; i < 30 && frames_done < 6; i++) begin
      step(1'b0, 16'd0, rpat[rk], 1'b0);
      rk++;
    end
    chk("bp_frames", 32'(frames_done), 6);
    chk("bp_ovr", 32'(ovr_cnt), 0);

    // Overrun: restart clean, then stall 40 cycles while 16 samples arrive
    step(1'b0, 16'd0, 1'b1, 1'b1);
    exp_first = 1; exp_fnum = 0; beat = 0;
    chk("ovr_flush_primed", 32'(primed_o), 0);
    chk("ovr_flush_fnum", 32'(frame_num_o), 0);
    for (int v = 1; v <= 16; v++) step(1'b1, 16'(v), 1'b0, 1'b0);
    repeat (24) step(1'b0, 16'd0, 1'b0, 1'b0);
    chk("ovr_stall_valid", 32'(frame_valid_o), 1);
    idle_until_frames(7, 20);
    chk("ovr_frames", 32'(frames_done), 7);
    chk("ovr_count", 32'(ovr_cnt), 2);
    chk("ovr_first_at", 32'(ovr_at[0]), 12);
    chk("ovr_second_at", 32'(ovr_at[1]), 16);
    chk("ovr_fnum_after", 32'(frame_num_o), 1);

    // Flush mid-frame at idx 3; the sample in the flush cycle is discarded
    step(1'b0, 16'd0, 1'b1, 1'b1);
    exp_first = 1; exp_fnum = 0; beat = 0;
    for (int v = 1; v <= 8; v++) step(1'b1, 16'(v), 1'b1, 1'b0);
    for (int i = 0; i < 10 && beat != 3; i++) step(1'b0, 16'd0, 1'b1, 1'b0);
    chk("flush_at_idx", 32'(frame_idx_o), 3);
    step(1'b1, 16'd999, 1'b1, 1'b1);
    chk("flush_valid", 32'(frame_valid_o), 0);
    chk("flush_primed", 32'(primed_o), 0);
    chk("flush_fnum", 32'(frame_num_o), 0);
    exp_first = 101; exp_fnum = 0; beat = 0;
    valid_cycles = 0;
    for (int v = 101; v <= 107; v++) step(1'b1, 16'(v), 1'b1, 1'b0);
    repeat (3) step(1'b0, 16'd0, 1'b1, 1'b0);
    chk("flush_no_early_frame", 32'(valid_cycles), 0);
    chk("flush_not_primed", 32'(primed_o), 0);
    step(1'b1, 16'd108, 1'b1, 1'b0);
    idle_until_frames(8, 20);
    chk("flush_frames", 32'(frames_done), 8);

    // Asynchronous reset mid-stream of frame 105..112
    for (int v = 109; v <= 112; v++) step(1'b1, 16'(v), 1'b1, 1'b0);
    for (int i = 0; i < 10 && beat != 2; i++) step(1'b0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(frame_valid_o), 1);
    #3;
    reset_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(frame_valid_o), 0);
    chk("arst_data", 32'(frame_data_o), 0);
    chk("arst_idx", 32'(frame_idx_o), 0);
    chk("arst_fnum", 32'(frame_num_o), 0);
    chk("arst_primed", 32'(primed_o), 0);
    chk("arst_overrun", 32'(overrun_o), 0);
    held = 1'b0;
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    exp_first = 1; exp_fnum = 0; beat = 0;
    prime_run("recover");
    chk("recover_frames", 32'(frames_done), 9);
    chk("recover_fnum", 32'(frame_num_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
